// File: rtl/mgpio_pkg.sv
// mgpio_pkg: constants and helpers shared by the GPIO input conditioning blocks.
//   MGPIO_BANK_WIDTH     : pins per GPIO bank
//   mgpio_cnt_width()    : width of a counter that must hold 0..cycles
package mgpio_pkg;

    localparam int MGPIO_BANK_WIDTH = 8;

    function automatic int mgpio_cnt_width(int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mgpio_in_pin.sv
// mgpio_in_pin: conditioning for one GPIO pad input.
// Two-flop synchroniser, optional stable-count debounce, registered
// rise/fall detection and a sticky interrupt-pending flag.
// Build option: MGPIO_DEBOUNCE_EN selects the debounce counter; without it
// the filtered value is simply a flop of the synchroniser output.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   pad_in        raw pad (asynchronous to clk)
//   irq_en        interrupt enable for this pin
//   irq_clr       level-sensitive pending clear
//   gpio_in       filtered pin value
//   edge_rise     one-cycle pulse on filtered 0->1
//   edge_fall     one-cycle pulse on filtered 1->0
//   irq_pending   sticky pending flag
//   pend_next     next-state of the pending flag, for the parent's irq flop
module mgpio_in_pin
    import mgpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    input  logic irq_en,
    input  logic irq_clr,
    output logic gpio_in,
    output logic edge_rise,
    output logic edge_fall,
    output logic irq_pending,
    output logic pend_next
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("mgpio_in_pin: DEBOUNCE_CYCLES must be within 1..65535");
    end

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic gpio_q, gpio_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic pend_q, pend_d;

`ifdef MGPIO_DEBOUNCE_EN
    localparam int CNT_W = mgpio_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        s1_d = pad_in;
        s2_d = s1_q;
`ifdef MGPIO_DEBOUNCE_EN
        // Count consecutive cycles of disagreement; any agreement restarts
        // the count, so the terminal compare also bounds the counter.
        gpio_d = gpio_q;
        cnt_d  = '0;
        if (s2_q != gpio_q) begin
            if (cnt_q == CNT_LAST) begin
                gpio_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`else
        gpio_d = s2_q;
`endif
        // Edges are computed from the next filtered value so the pulse lines
        // up with the cycle in which gpio_in first shows the new level.
        rise_d = gpio_d & ~gpio_q;
        fall_d = ~gpio_d & gpio_q;
        // Set wins over clear.
        pend_d = (pend_q & ~irq_clr) | ((rise_q | fall_q) & irq_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            gpio_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            gpio_q <= gpio_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

`ifdef MGPIO_DEBOUNCE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign gpio_in     = gpio_q;
    assign edge_rise   = rise_q;
    assign edge_fall   = fall_q;
    assign irq_pending = pend_q;
    assign pend_next   = pend_d;

endmodule

// File: rtl/mgpio_in_cond.sv
// mgpio_in_cond: input conditioning between the GPIO pads and mgpio.gpio_in.
// One mgpio_in_pin per pin plus a registered OR of the pending flags.
// Build option: MGPIO_DEBOUNCE_EN enables the per-pin debounce counters;
// when undefined DEBOUNCE_CYCLES has no effect.
// Ports (N = BANKS*8):
//   clk, rst      clock, asynchronous active-low reset
//   pad_in[N]     raw pad inputs
//   gpio_in[N]    filtered pin values
//   edge_rise[N]  filtered rising-edge pulses
//   edge_fall[N]  filtered falling-edge pulses
//   irq_en[N]     per-pin interrupt enable
//   irq_clr[N]    per-pin pending clear (level)
//   irq_pending[N] sticky pending flags
//   irq           registered OR of pending flags
module mgpio_in_cond
    import mgpio_pkg::*;
#(
    parameter int BANKS           = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BANKS*MGPIO_BANK_WIDTH-1:0]   pad_in,
    output logic [BANKS*MGPIO_BANK_WIDTH-1:0]   gpio_in,
    output logic [BANKS*MGPIO_BANK_WIDTH-1:0]   edge_rise,
    output logic [BANKS*MGPIO_BANK_WIDTH-1:0]   edge_fall,
    input  logic [BANKS*MGPIO_BANK_WIDTH-1:0]   irq_en,
    input  logic [BANKS*MGPIO_BANK_WIDTH-1:0]   irq_clr,
    output logic [BANKS*MGPIO_BANK_WIDTH-1:0]   irq_pending,
    output logic                                irq
);

    localparam int N = BANKS * MGPIO_BANK_WIDTH;

    logic [N-1:0] pend_next;
    logic         irq_q, irq_d;

    for (genvar i = 0; i < N; i++) begin : g_pin
        mgpio_in_pin #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_pin (
            .clk         (clk),
            .rst         (rst),
            .pad_in      (pad_in[i]),
            .irq_en      (irq_en[i]),
            .irq_clr     (irq_clr[i]),
            .gpio_in     (gpio_in[i]),
            .edge_rise   (edge_rise[i]),
            .edge_fall   (edge_fall[i]),
            .irq_pending (irq_pending[i]),
            .pend_next   (pend_next[i])
        );
    end

    // Reducing the next-state keeps irq in step with irq_pending.
    always_comb begin
        irq_d = |pend_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
